// File: rtl/shifter32_right_seq_pkg.sv
// Shared definitions for the multicycle right shifter: data widths,
// controller state encoding and the set of supported per-cycle step sizes.
package shifter32_right_seq_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Step sizes the datapath is built for.
  function automatic bit step_legal(input int unsigned step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8);
  endfunction

endpackage

// File: rtl/shifter32_right_seq_if.sv
// Request/response bundle between the EX-stage issue logic (master) and the
// right shifter (slave).
interface shifter32_right_seq_if;
  import shifter32_right_seq_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   I;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               flush;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   Q;

  modport master (
    output start, I, shamt, arith, flush,
    input  busy, done, Q
  );

  modport slave (
    input  start, I, shamt, arith, flush,
    output busy, done, Q
  );

endinterface

// File: rtl/shifter32_right_seq_shift_right_step.sv
// Combinational single-step right shift: moves work right by amount and
// fills the vacated top bits with fill.
module shifter32_right_seq_shift_right_step
  import shifter32_right_seq_pkg::*;
(
  input  logic [WIDTH-1:0]   work,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               fill,
  output logic [WIDTH-1:0]   shifted
);

  // Logical shift, then OR in the fill pattern over the vacated bits.
  always_comb begin
    shifted = (work >> amount) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> amount));
  end

endmodule

// File: rtl/shifter32_right_seq.sv
// Multicycle SRL/SRA unit: shifts a 32-bit operand right by 0-31, STEP bits
// per cycle, with a start/busy/done handshake and a pipeline flush abort.
module shifter32_right_seq
  import shifter32_right_seq_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input logic                  clk,
  input logic                  rst,
  shifter32_right_seq_if.slave bus
);

  if (!step_legal(STEP)) begin : g_illegal_step
    $error("shifter32_right_seq: STEP must be 1, 2, 4 or 8");
  end

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] amount;
  logic [SHAMT_W-1:0] cnt_next;
  logic               fill;
  logic               accept;

  // Per-cycle shift amount: a full step, or only the remainder on the last one.
  always_comb begin
    amount   = (cnt < STEP_AMT) ? cnt : STEP_AMT;
    cnt_next = cnt - amount;
    accept   = bus.start & ~bus.flush;
  end

  shifter32_right_seq_shift_right_step u_step (
    .work    (work),
    .amount  (amount),
    .fill    (fill),
    .shifted (shifted)
  );

  // Controller and datapath registers; new requests are taken in IDLE or DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      fill  <= 1'b0;
      q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            work <= bus.I;
            cnt  <= bus.shamt;
            fill <= bus.arith & bus.I[WIDTH-1];
            if (bus.shamt == '0) begin
              state <= DONE;
              q     <= bus.I;
            end else begin
              state <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            work <= shifted;
            cnt  <= cnt_next;
            if (cnt_next == '0) begin
              state <= DONE;
              q     <= shifted;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    bus.busy = (state == SHIFT);
    bus.done = (state == DONE);
    bus.Q    = q;
  end

endmodule

// File: tb/tb_shifter32_right_seq.sv
// Self-checking bench: STEP=1 and STEP=4 instances run the same stimulus and
// are compared against an arithmetic reference for result and latency.
module tb_shifter32_right_seq;
  import shifter32_right_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        arith;
  logic        flush;
  logic [31:0] opnd;
  logic [4:0]  shamt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q;

  always #5 clk = ~clk;

  shifter32_right_seq_if bus1 ();
  shifter32_right_seq_if bus4 ();

  assign bus1.start = start;
  assign bus1.I     = opnd;
  assign bus1.shamt = shamt;
  assign bus1.arith = arith;
  assign bus1.flush = flush;
  assign bus4.start = start;
  assign bus4.I     = opnd;
  assign bus4.shamt = shamt;
  assign bus4.arith = arith;
  assign bus4.flush = flush;

  shifter32_right_seq #(.STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  shifter32_right_seq #(.STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int sh, input bit ar);
    if (ar) return $signed(v) >>> sh;
    return v >> sh;
  endfunction

  function automatic int ref_latency(input int sh, input int step);
    return 1 + (sh + step - 1) / step;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy1"}, 32'(bus1.busy), 32'd0);
    check({tag, "_done1"}, 32'(bus1.done), 32'd0);
    check({tag, "_busy4"}, 32'(bus4.busy), 32'd0);
    check({tag, "_done4"}, 32'(bus4.done), 32'd0);
  endtask

  // One operation on both instances; poke_at>=2 issues a junk start mid-shift.
  task automatic run_op(input logic [31:0] v, input logic [4:0] sh, input bit ar,
                        input int poke_at);
    int lat1, lat4, busy1, busy4, exp1, exp4;
    logic [31:0] prev;
    exp1  = ref_latency(int'(sh), 1);
    exp4  = ref_latency(int'(sh), 4);
    prev  = exp_q;
    exp_q = ref_shift(v, int'(sh), ar);
    lat1 = 0; lat4 = 0; busy1 = 0; busy4 = 0;
    opnd = v; shamt = sh; arith = ar; start = 1'b1;
    for (int n = 1; n <= 40 && (lat1 == 0 || lat4 == 0); n++) begin
      tick();
      start = (n == poke_at);
      if (n == poke_at) begin
        opnd = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
      end
      if (lat1 != 0) begin
        check("idle_after_done1", {30'd0, bus1.busy, bus1.done}, 32'd0);
      end else if (bus1.done) begin
        lat1 = n;
        check("q_step1", bus1.Q, exp_q);
      end else begin
        if (bus1.busy) busy1++;
        check("q_hold_step1", bus1.Q, prev);
      end
      if (lat4 != 0) begin
        check("idle_after_done4", {30'd0, bus4.busy, bus4.done}, 32'd0);
      end else if (bus4.done) begin
        lat4 = n;
        check("q_step4", bus4.Q, exp_q);
      end else begin
        if (bus4.busy) busy4++;
        check("q_hold_step4", bus4.Q, prev);
      end
    end
    start = 1'b0;
    check("latency_step1", 32'(lat1), 32'(exp1));
    check("latency_step4", 32'(lat4), 32'(exp4));
    check("busy_cycles_step1", 32'(busy1), 32'(exp1 - 1));
    check("busy_cycles_step4", 32'(busy4), 32'(exp4 - 1));
    tick();
    check_quiet("after_op");
    check("q_after_op1", bus1.Q, exp_q);
    check("q_after_op4", bus4.Q, exp_q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; arith = 1'b0; opnd = '0; shamt = '0;
    exp_q = '0;
    tick(); tick();
    rst = 1'b0;
    check_quiet("reset");
    check("reset_q1", bus1.Q, 32'h0);
    check("reset_q4", bus4.Q, 32'h0);

    // Directed cases.
    run_op(32'h8000_0000, 5'd31, 1'b0, 0);
    check("srl31_const", bus1.Q, 32'h0000_0001);
    run_op(32'h8000_0000, 5'd4, 1'b1, 0);
    check("sra4_neg_const", bus1.Q, 32'hF800_0000);
    run_op(32'h7FFF_FFFF, 5'd4, 1'b1, 0);
    check("sra4_pos_const", bus4.Q, 32'h07FF_FFFF);
    run_op(32'hDEAD_BEEF, 5'd0, 1'b0, 0);
    run_op(32'h8000_0000, 5'd31, 1'b1, 0);
    check("sra31_const", bus4.Q, 32'hFFFF_FFFF);
    run_op(32'h1234_5678, 5'd9, 1'b0, 2);
    check("srl9_poke_const", bus4.Q, 32'h0009_1A2B);

    // Flush mid-shift keeps the old result and suppresses done.
    run_op(32'h8000_0000, 5'd31, 1'b0, 0);
    opnd = 32'hABCD_1234; shamt = 5'd20; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("flush_pre_busy1", 32'(bus1.busy), 32'd1);
    check("flush_pre_busy4", 32'(bus4.busy), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_quiet("flush");
    check("flush_q1", bus1.Q, 32'h0000_0001);
    check("flush_q4", bus4.Q, 32'h0000_0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_quiet("post_flush");
    end
    run_op(32'h0000_0100, 5'd8, 1'b0, 0);

    // Reset mid-shift.
    opnd = 32'h8765_4321; shamt = 5'd20; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q = '0;
    check_quiet("mid_rst");
    check("mid_rst_q1", bus1.Q, 32'h0);
    check("mid_rst_q4", bus4.Q, 32'h0);

    // start together with flush while idle is dropped.
    opnd = 32'hDEAD_BEEF; shamt = 5'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check_quiet("start_flush");
    check("start_flush_q1", bus1.Q, exp_q);
    tick();
    check_quiet("start_flush_next");

    // Back-to-back zero-shift ops: second start is taken in DONE.
    opnd = 32'h1111_2222; shamt = 5'd0; arith = 1'b0; start = 1'b1;
    tick();
    check("b2b_first_done1", 32'(bus1.done), 32'd1);
    check("b2b_first_q4", bus4.Q, 32'h1111_2222);
    opnd = 32'h3333_4444;
    tick();
    start = 1'b0;
    check("b2b_second_done4", 32'(bus4.done), 32'd1);
    check("b2b_second_q1", bus1.Q, 32'h3333_4444);
    exp_q = 32'h3333_4444;
    tick();
    check_quiet("b2b_end");

    // Randomised operations with the extremes forced periodically.
    for (int k = 0; k < 24; k++) begin
      logic [4:0]  sh;
      logic [31:0] v;
      v  = $urandom;
      sh = 5'($urandom_range(0, 31));
      if (k % 8 == 0) sh = 5'd0;
      if (k % 8 == 1) sh = 5'd31;
      run_op(v, sh, 1'($urandom % 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
